sr_shift_out_driver: RTL and testbench
======================================

Name: sr_shift_out_driver

Overview:
- Serial-in/parallel-out shift-register transmitter, 74HC595 style. It drives a daisy-chained register bank with clock, data and latch.
- It is the transmit counterpart of the sensor shift-register reader. The sensor side shifts bits in from a parallel-load chain; this block shifts a parallel word out to an output chain, e.g. board-status indicator lamps.
- The CPU-facing memory manager presents a word and pulses start. The block serialises the word MSB-first and latches it.

Parameters:
- WIDTH, 32: bits per frame (chain length); >= 1.
- CLK_DIV, 50: system clocks per sr_clk half-period; >= 1.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to send data_in; sampled every cycle.
- data_in  in  WIDTH  word to transmit; captured in the cycle start is sampled.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame's latch phase completes.
- pending  out  1  a queued frame is waiting.
- sr_clk  out  1  shift clock to the chain; data is shifted on its rising edge.
- sr_data  out  1  serial data; MSB of the frame first.
- sr_latch  out  1  storage-register latch pulse, active high.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; shift register, bit counter, divider counter and pending buffer all cleared. Reset mid-frame aborts the frame immediately, with no latch pulse. After release, the block is in IDLE on the next edge.
- All outputs are registered. No combinational path from inputs to outputs.
- States are IDLE, LOW, HIGH, LATCH.
- IDLE → LOW, accept:
  - Condition: start=1 at an edge while in IDLE.
  - Captures data_in into the shift register and sets busy=1.
  - sr_data takes data_in[WIDTH-1]; bit count = 0; divider = 0.
- LOW: sr_clk=0 for CLK_DIV cycles (data setup), then → HIGH.
- HIGH:
  - sr_clk=1 for CLK_DIV cycles.
  - On exit: shift left by one, sr_data takes the next bit, bit count increments.
  - If bit count reaches WIDTH → LATCH; otherwise → LOW.
- LATCH:
  - sr_clk=0 and sr_latch=1 for CLK_DIV cycles; sr_data holds the last bit.
  - On exit: sr_latch=0 and done=1 for exactly one cycle.
  - If pending=1: re-enter LOW with the buffered word, busy stays 1 and pending clears.
  - Otherwise: → IDLE and busy=0 in the same cycle as done.
- Frame length: busy is high for exactly (2*WIDTH+1)*CLK_DIV cycles per frame. Exactly WIDTH rising edges of sr_clk and one latch pulse per frame.
- start while busy:
  - Copies data_in into the pending buffer and sets pending=1.
  - Later starts overwrite the buffer; last value wins and at most one frame is queued.
  - start in the same cycle the frame's done fires is treated as "while busy": it is queued and sent back-to-back.
- start held high continuously in IDLE: one frame is accepted. Further frames are queued on each busy cycle, giving continuous refresh with the latest data.
- data_in changes during a frame have no effect on the current frame.
- Divider and bit counters are sized $clog2(CLK_DIV+1) and $clog2(WIDTH+1). Counters never wrap: each is compared to its limit and cleared.

Decomposition:
- Shared package sr_pkg holds:
  - the state enum (IDLE, LOW, HIGH, LATCH);
  - default WIDTH and CLK_DIV constants shared with the sensor reader, so both chains run at the same shift rate.
- One natural sub-module: sr_tick_divider.
  - Free-running when enabled, cleared on phase entry.
  - Emits a one-cycle phase_end after CLK_DIV cycles.
- The FSM, shift register and pending buffer stay in the top module.

Test Plan (WIDTH=8, CLK_DIV=2 unless noted):
- Reset then idle → busy=0, done=0, pending=0, sr_clk=0, sr_data=0, sr_latch=0; no activity for 100 cycles.
- One-cycle start with data_in=8'hA5:
  - sr_data sampled at the 8 sr_clk rises = 1,0,1,0,0,1,0,1.
  - One sr_latch pulse 2 cycles wide after the 8th rise.
  - busy high for 34 cycles; done pulses once, in the cycle busy falls.
- Start 8'h3C, then start 8'h11 at cycle 5 and 8'hF0 at cycle 9:
  - pending=1 from cycle 6.
  - The second frame transmits 8'hF0 back-to-back; busy never drops between frames.
  - Two done pulses.
- Assert reset at cycle 10 of a frame (data 8'hFF):
  - All outputs 0 immediately; no latch pulse.
  - A new start 8'h01 after release yields a clean 34-cycle frame.
- WIDTH=1, CLK_DIV=1 with data 1'b1 → one sr_clk rise with sr_data=1, sr_latch one cycle, busy for 3 cycles.
- Change data_in every cycle during a frame started with 8'h81 → serial stream is still 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register chain drivers.
// Holds the transmitter FSM state encoding and the default chain geometry
// (frame width and shift-clock divider) shared with the sensor reader, so
// both chains run at the same shift rate.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } sr_state_e;

  localparam int SR_WIDTH   = 32;
  localparam int SR_CLK_DIV = 50;

endpackage

// File: rtl/sr_tick_divider.sv
// Phase-length divider for the shift-out driver.
// Counts system clocks while enabled and pulses phase_end_o for one cycle
// on the CLK_DIV-th cycle of each phase, then restarts from zero so the
// next phase begins with a fresh count.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   en_i        count enable (a frame is in progress)
//   clr_i       synchronous clear (held while idle)
//   phase_end_o one-cycle pulse in the last cycle of a phase
import sr_pkg::*;

module sr_tick_divider #(
  parameter int CLK_DIV = SR_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic phase_end_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LIMIT = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign phase_end_o = en_i && !clr_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Compare against the limit and clear rather than relying on wrap.
      cnt_d = (cnt_q == LIMIT) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sr_shift_out_driver.sv
// 74HC595-style serial transmitter for a daisy-chained output register bank.
// A word presented with start is shifted out MSB-first on sr_data, one bit
// per sr_clk period (CLK_DIV clocks low, CLK_DIV clocks high; the chain
// shifts on the sr_clk rising edge), then sr_latch is held high for CLK_DIV
// clocks to transfer the chain into its storage registers.
// A start arriving while a frame is in progress is held in a one-deep
// pending buffer (last value wins) and sent back-to-back.
// Ports:
//   clock, reset      system clock, asynchronous active-low reset
//   start, data_in    transmit request and the word to send
//   busy, done        frame in progress / one-cycle completion pulse
//   pending           a queued word is waiting
//   sr_clk, sr_data   shift clock and serial data to the chain
//   sr_latch          storage-register latch pulse
// Handshake: start is a plain request sampled every clock; no ready is
// returned, a request is either accepted (idle) or queued (busy), never lost
// except when overwritten in the pending buffer by a newer request.
import sr_pkg::*;

module sr_shift_out_driver #(
  parameter int WIDTH   = SR_WIDTH,
  parameter int CLK_DIV = SR_CLK_DIV
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             pending,
  output logic             sr_clk,
  output logic             sr_data,
  output logic             sr_latch
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  sr_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             latch_q, latch_d;
  logic             phase_end;

  sr_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i      (clock),
    .rst_ni     (reset),
    .en_i       (state_q != IDLE),
    .clr_i      (state_q == IDLE),
    .phase_end_o(phase_end)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    buf_d   = buf_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    clk_d   = clk_q;
    latch_d = latch_q;

    // Any request outside IDLE (including the cycle the frame completes)
    // lands in the pending buffer.
    if (start && state_q != IDLE) begin
      pend_d = 1'b1;
      buf_d  = data_in;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOW;
          shreg_d = data_in;
          bit_d   = '0;
          busy_d  = 1'b1;
          clk_d   = 1'b0;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_d = HIGH;
          clk_d   = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          clk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            // No shift on the last bit so sr_data holds it through LATCH.
            state_d = LATCH;
            latch_d = 1'b1;
            bit_d   = '0;
          end else begin
            state_d = LOW;
            shreg_d = shreg_q << 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          latch_d = 1'b0;
          done_d  = 1'b1;
          if (pend_q) begin
            // Send the buffered word; a same-cycle start has already
            // refilled the buffer above and keeps pending set.
            state_d = LOW;
            shreg_d = buf_q;
            pend_d  = start;
          end else if (start) begin
            // Queue-and-dequeue in one step: go straight to the new word.
            state_d = LOW;
            shreg_d = data_in;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            shreg_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      buf_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      buf_q   <= buf_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      latch_q <= latch_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pending  = pend_q;
  assign sr_clk   = clk_q;
  assign sr_data  = shreg_q[WIDTH-1];
  assign sr_latch = latch_q;

endmodule

// File: tb/tb_sr_shift_out_driver.sv
// Directed bench for sr_shift_out_driver: an 8-bit / divide-by-2 instance
// and a 1-bit / divide-by-1 instance sharing clock and reset.
module tb_sr_shift_out_driver;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: WIDTH=8, CLK_DIV=2 ----------------
  logic       a_start = 1'b0;
  logic [7:0] a_data  = 8'h00;
  logic a_busy, a_done, a_pending, a_sr_clk, a_sr_data, a_sr_latch;

  sr_shift_out_driver #(.WIDTH(8), .CLK_DIV(2)) dut_a (
    .clock   (clk),
    .reset   (rst_n),
    .start   (a_start),
    .data_in (a_data),
    .busy    (a_busy),
    .done    (a_done),
    .pending (a_pending),
    .sr_clk  (a_sr_clk),
    .sr_data (a_sr_data),
    .sr_latch(a_sr_latch)
  );

  // ---------------- DUT B: WIDTH=1, CLK_DIV=1 ----------------
  logic       b_start = 1'b0;
  logic [0:0] b_data  = 1'b0;
  logic b_busy, b_done, b_pending, b_sr_clk, b_sr_data, b_sr_latch;

  sr_shift_out_driver #(.WIDTH(1), .CLK_DIV(1)) dut_b (
    .clock   (clk),
    .reset   (rst_n),
    .start   (b_start),
    .data_in (b_data),
    .busy    (b_busy),
    .done    (b_done),
    .pending (b_pending),
    .sr_clk  (b_sr_clk),
    .sr_data (b_sr_data),
    .sr_latch(b_sr_latch)
  );

  // ---------------- scoreboard / counters ----------------
  logic [0:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int a_busy_cyc = 0, a_busy_falls = 0, a_latch_cyc = 0, a_latch_rises = 0;
  int a_rises_at_latch = 0, a_done_cnt = 0, a_done_idle = 0, a_rise_cnt = 0;
  logic prev_a_clk = 1'b0, prev_a_latch = 1'b0, prev_a_busy = 1'b0;

  int b_busy_cyc = 0, b_latch_cyc = 0, b_done_cnt = 0, b_rise_cnt = 0;
  logic b_rise_data = 1'b0, prev_b_clk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and sample both DUTs there.
  task automatic tick();
    @(negedge clk);
    if (a_busy) a_busy_cyc++;
    if (prev_a_busy && !a_busy) a_busy_falls++;
    if (a_sr_latch) a_latch_cyc++;
    if (a_sr_latch && !prev_a_latch) begin
      a_latch_rises++;
      a_rises_at_latch = a_rise_cnt;
    end
    if (a_done) begin
      a_done_cnt++;
      if (!a_busy) a_done_idle++;
    end
    if (a_sr_clk && !prev_a_clk) begin
      a_rise_cnt++;
      chk("a_bit_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("a_sr_data", 32'(a_sr_data), 32'(exp_q.pop_front()));
    end
    prev_a_clk   = a_sr_clk;
    prev_a_latch = a_sr_latch;
    prev_a_busy  = a_busy;

    if (b_busy) b_busy_cyc++;
    if (b_sr_latch) b_latch_cyc++;
    if (b_done) b_done_cnt++;
    if (b_sr_clk && !prev_b_clk) begin
      b_rise_cnt++;
      b_rise_data = b_sr_data;
    end
    prev_b_clk = b_sr_clk;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic send_a(input logic [7:0] w);
    a_data  = w;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input int n, input bit scramble);
    int base;
    int guard;
    base  = a_done_cnt;
    guard = 0;
    while ((a_done_cnt - base) < n && guard < 400) begin
      if (scramble) a_data = 8'($urandom_range(0, 255));
      tick();
      guard++;
    end
    chk("a_done_timeout", 32'((a_done_cnt - base) >= n), 32'd1);
    a_data = 8'h00;
    repeat (3) tick();
  endtask

  task automatic chk_a_idle_outputs(input string tag);
    chk({tag, "_busy"},    32'(a_busy),     32'd0);
    chk({tag, "_done"},    32'(a_done),     32'd0);
    chk({tag, "_pending"}, 32'(a_pending),  32'd0);
    chk({tag, "_sr_clk"},  32'(a_sr_clk),   32'd0);
    chk({tag, "_sr_data"}, 32'(a_sr_data),  32'd0);
    chk({tag, "_sr_latch"},32'(a_sr_latch), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bb, br, bl, bd, bra, bdi, bf;
    int b_bb, b_br, b_bl, b_bd;

    // Reset and idle.
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk_a_idle_outputs("reset");
    chk("reset_b_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    bb = a_busy_cyc; br = a_rise_cnt; bl = a_latch_rises; bd = a_done_cnt;
    repeat (100) tick();
    chk("idle_busy_cycles", 32'(a_busy_cyc - bb), 32'd0);
    chk("idle_sr_clk_rises", 32'(a_rise_cnt - br), 32'd0);
    chk("idle_latch_pulses", 32'(a_latch_rises - bl), 32'd0);
    chk("idle_done_pulses", 32'(a_done_cnt - bd), 32'd0);
    chk_a_idle_outputs("idle");

    // Single frame 8'hA5.
    bb = a_busy_cyc; br = a_rise_cnt; bl = a_latch_rises; bd = a_done_cnt;
    bdi = a_done_idle; bf = a_latch_cyc;
    push_exp(8'hA5);
    send_a(8'hA5);
    chk("a5_sr_data_first", 32'(a_sr_data), 32'd1);
    wait_a_done(1, 1'b0);
    chk("a5_busy_cycles", 32'(a_busy_cyc - bb), 32'd34);
    chk("a5_sr_clk_rises", 32'(a_rise_cnt - br), 32'd8);
    chk("a5_latch_pulses", 32'(a_latch_rises - bl), 32'd1);
    chk("a5_latch_width", 32'(a_latch_cyc - bf), 32'd2);
    chk("a5_latch_after_rises", 32'(a_rises_at_latch - br), 32'd8);
    chk("a5_done_pulses", 32'(a_done_cnt - bd), 32'd1);
    chk("a5_done_with_busy_low", 32'(a_done_idle - bdi), 32'd1);
    chk("a5_bits_left", 32'(exp_q.size()), 32'd0);
    chk_a_idle_outputs("a5_end");

    // Queued frames: 3C, then 11 at edge 5 and F0 at edge 9 (F0 wins).
    bb = a_busy_cyc; br = a_rise_cnt; bl = a_latch_rises; bd = a_done_cnt;
    bdi = a_done_idle; bf = a_busy_falls;
    push_exp(8'h3C);
    push_exp(8'hF0);
    send_a(8'h3C);
    repeat (4) tick();
    a_data  = 8'h11;
    a_start = 1'b1;
    chk("q_pending_before", 32'(a_pending), 32'd0);
    tick();
    a_start = 1'b0;
    chk("q_pending_after_11", 32'(a_pending), 32'd1);
    repeat (3) tick();
    a_data  = 8'hF0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("q_pending_after_f0", 32'(a_pending), 32'd1);
    wait_a_done(2, 1'b0);
    chk("q_busy_cycles", 32'(a_busy_cyc - bb), 32'd68);
    chk("q_busy_falls", 32'(a_busy_falls - bf), 32'd1);
    chk("q_sr_clk_rises", 32'(a_rise_cnt - br), 32'd16);
    chk("q_latch_pulses", 32'(a_latch_rises - bl), 32'd2);
    chk("q_done_pulses", 32'(a_done_cnt - bd), 32'd2);
    chk("q_done_with_busy_low", 32'(a_done_idle - bdi), 32'd1);
    chk("q_bits_left", 32'(exp_q.size()), 32'd0);
    chk_a_idle_outputs("q_end");

    // Reset in the middle of an 8'hFF frame.
    bl = a_latch_rises;
    push_exp(8'hFF);
    send_a(8'hFF);
    repeat (9) tick();
    chk("rst_busy_before", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_a_idle_outputs("midrst");
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("midrst_latch_pulses", 32'(a_latch_rises - bl), 32'd0);
    chk_a_idle_outputs("midrst_release");
    bb = a_busy_cyc; br = a_rise_cnt; bl = a_latch_rises; bd = a_done_cnt;
    push_exp(8'h01);
    send_a(8'h01);
    wait_a_done(1, 1'b0);
    chk("post_busy_cycles", 32'(a_busy_cyc - bb), 32'd34);
    chk("post_sr_clk_rises", 32'(a_rise_cnt - br), 32'd8);
    chk("post_latch_pulses", 32'(a_latch_rises - bl), 32'd1);
    chk("post_done_pulses", 32'(a_done_cnt - bd), 32'd1);
    chk("post_bits_left", 32'(exp_q.size()), 32'd0);

    // data_in scrambled every cycle during an 8'h81 frame.
    br = a_rise_cnt;
    push_exp(8'h81);
    send_a(8'h81);
    wait_a_done(1, 1'b1);
    chk("scr_sr_clk_rises", 32'(a_rise_cnt - br), 32'd8);
    chk("scr_bits_left", 32'(exp_q.size()), 32'd0);
    chk("scr_pending", 32'(a_pending), 32'd0);

    // Minimum geometry: WIDTH=1, CLK_DIV=1.
    b_bb = b_busy_cyc; b_br = b_rise_cnt; b_bl = b_latch_cyc; b_bd = b_done_cnt;
    b_data  = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_data  = 1'b0;
    for (int i = 0; i < 20 && (b_done_cnt - b_bd) == 0; i++) tick();
    repeat (2) tick();
    chk("w1_done_pulses", 32'(b_done_cnt - b_bd), 32'd1);
    chk("w1_sr_clk_rises", 32'(b_rise_cnt - b_br), 32'd1);
    chk("w1_sr_data_at_rise", 32'(b_rise_data), 32'd1);
    chk("w1_latch_width", 32'(b_latch_cyc - b_bl), 32'd1);
    chk("w1_busy_cycles", 32'(b_busy_cyc - b_bb), 32'd3);
    chk("w1_busy_end", 32'(b_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
